// File: rtl/spi_reg_pkg.sv
// Shared constants and types for the SPI register responder.
package spi_reg_pkg;

  localparam logic [7:0]  CMD_WR          = 8'h80;
  localparam logic [7:0]  CMD_RD          = 8'h00;

  localparam int          STAT_ABORT      = 0;
  localparam int          STAT_BAD        = 1;
  localparam int          STAT_TIMEOUT    = 2;

  localparam logic [31:0] RD_TIMEOUT_DATA = 32'hDEAD_BEEF;

  // Bit counts at which each frame phase ends.
  localparam int          CMD_END         = 8;
  localparam int          ADDR_END        = 24;
  localparam int          TURN_END        = 32;
  localparam int          FRAME_END       = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_TURN,
    S_DATA,
    S_DONE
  } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer with registered level and edge pulses.
// The level output is aligned with the rise/fall pulses.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic level_q, level_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  // Shift the pad value in and derive edges against the previous level.
  always_comb begin
    sync_d  = (sync_q << 1) | SYNC_STAGES'(din);
    level_d = sync_q[SYNC_STAGES-1];
    rise_d  = level_d & ~level_q;
    fall_d  = ~level_d & level_q;
  end

  // Synchronizer and level keep running through reset so the first
  // cycle after release never produces a false edge.
  always_ff @(posedge clk) begin
    sync_q  <= sync_d;
    level_q <= level_d;
  end

  // Edge pulses are cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/spi_reg_slave.sv
// SPI mode-0 responder: one 64-bit frame -> one register write or read.
//
// state  | meaning
// IDLE   | deselected, waiting for ss_n fall
// CMD    | receiving command byte (bits 0-7)
// ADDR   | receiving address (bits 8-23); read issued at bit 23
// TURN   | turnaround (bits 24-31); status byte shifted out
// DATA   | data word (bits 32-63); write committed at bit 63
// DONE   | frame finished or unusable, waiting for ss_n high
module spi_reg_slave
  import spi_reg_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_sck,
  input  logic              spi_ss_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_wr,
  output logic              reg_rd,
  input  logic [DATA_W-1:0] reg_rdata,
  input  logic              reg_rd_ack,
  output logic              frame_err
);

  logic sck_level, sck_rise, sck_fall;
  logic ss_level, ss_rise, ss_fall;
  logic [SYNC_STAGES-1:0] mosi_q, mosi_d;
  logic mosi_s;

  state_t state_q, state_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [63:0] rx_q, rx_d, rx_shift;
  logic [31:0] tx_q, tx_d, tx_src;
  logic [2:0]  stat_q, stat_d;
  logic        is_rd_q, is_rd_d;
  logic        bad_q, bad_d;
  logic        rd_wait_q, rd_wait_d;
  logic        rd_ok_q, rd_ok_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [DATA_W-1:0] reg_wdata_q, reg_wdata_d;
  logic        reg_wr_q, reg_wr_d;
  logic        reg_rd_q, reg_rd_d;
  logic        frame_err_q, frame_err_d;
  logic        miso_q, miso_d;
  logic        oe_q, oe_d;
  logic [7:0]  hdr_cmd;
  logic [15:0] hdr_addr;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (spi_sck),
    .level (sck_level),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ss_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (spi_ss_n),
    .level (ss_level),
    .rise  (ss_rise),
    .fall  (ss_fall)
  );

  // MOSI only needs a synchronizer; it is stable around the SCK rise.
  always_comb begin
    mosi_d = (mosi_q << 1) | SYNC_STAGES'(spi_mosi);
  end

  // MOSI synchronizer flops.
  always_ff @(posedge clk) begin
    mosi_q <= mosi_d;
  end

  assign mosi_s   = mosi_q[SYNC_STAGES-1];
  assign rx_shift = (rx_q << 1) | 64'(mosi_s);
  assign hdr_cmd  = rx_shift[23:16];
  assign hdr_addr = rx_shift[15:0];

  // Frame FSM, shifters, status and register-bus strobes.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    tx_src      = tx_q;
    stat_d      = stat_q;
    is_rd_d     = is_rd_q;
    bad_d       = bad_q;
    rd_wait_d   = rd_wait_q;
    rd_ok_d     = rd_ok_q;
    rd_data_d   = rd_data_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_wr_d    = 1'b0;
    reg_rd_d    = 1'b0;
    frame_err_d = 1'b0;
    miso_d      = miso_q;
    oe_d        = ~ss_level;

    if (rd_wait_q && reg_rd_ack) begin
      rd_wait_d = 1'b0;
      rd_ok_d   = 1'b1;
      rd_data_d = reg_rdata;
    end

    case (state_q)
      S_IDLE: begin
        miso_d = 1'b0;
        if (ss_fall) begin
          // SCK high at select means the host is not in mode 0; sit the frame out.
          state_d   = sck_level ? S_DONE : S_CMD;
          bit_cnt_d = '0;
          rx_d      = '0;
          is_rd_d   = 1'b0;
          bad_d     = 1'b0;
          rd_wait_d = 1'b0;
          rd_ok_d   = 1'b0;
        end
      end
      S_DONE: begin
        miso_d = 1'b0;
        if (ss_level) state_d = S_IDLE;
      end
      default: begin
        if (sck_rise) begin
          rx_d      = rx_shift;
          bit_cnt_d = bit_cnt_q + 6'd1;
          if (bit_cnt_q == 6'(CMD_END - 1)) state_d = S_ADDR;
          if (bit_cnt_q == 6'(ADDR_END - 1)) begin
            state_d = S_TURN;
            if ((hdr_cmd != CMD_WR && hdr_cmd != CMD_RD) || hdr_addr[1:0] != 2'b00) begin
              bad_d = 1'b1;
            end else if (hdr_cmd == CMD_RD) begin
              is_rd_d    = 1'b1;
              reg_rd_d   = 1'b1;
              reg_addr_d = ADDR_W'(hdr_addr);
              rd_wait_d  = 1'b1;
              rd_ok_d    = 1'b0;
            end
          end
          if (bit_cnt_q == 6'(TURN_END - 1)) state_d = S_DATA;
          if (bit_cnt_q == 6'(FRAME_END - 1)) begin
            state_d = S_DONE;
            miso_d  = 1'b0;
            if (bad_q) begin
              frame_err_d      = 1'b1;
              stat_d[STAT_BAD] = 1'b1;
            end else if (!is_rd_q) begin
              reg_wr_d    = 1'b1;
              reg_addr_d  = ADDR_W'(rx_shift[55:40]);
              reg_wdata_d = rx_shift[31:0];
            end
          end
        end else if (sck_fall && bit_cnt_q >= 6'(ADDR_END)) begin
          if (bit_cnt_q == 6'(ADDR_END)) tx_src = {5'b0, stat_q, 24'b0};
          if (bit_cnt_q == 6'(TURN_END)) begin
            // Previous status has been fully shifted out; start this frame's.
            stat_d    = '0;
            rd_wait_d = 1'b0;
            if (is_rd_q && rd_ok_q) begin
              tx_src = rd_data_q;
            end else if (is_rd_q) begin
              tx_src               = RD_TIMEOUT_DATA;
              stat_d[STAT_TIMEOUT] = 1'b1;
            end else begin
              tx_src = '0;
            end
          end
          miso_d = tx_src[31];
          tx_d   = tx_src << 1;
        end

        // A deselect landing with the last bit still completes the frame.
        if (ss_rise && !(sck_rise && bit_cnt_q == 6'(FRAME_END - 1))) begin
          state_d            = S_IDLE;
          miso_d             = 1'b0;
          stat_d[STAT_ABORT] = 1'b1;
          frame_err_d        = 1'b1;
          rd_wait_d          = 1'b0;
          reg_rd_d           = 1'b0;
          reg_addr_d         = reg_addr_q;
        end
      end
    endcase
  end

  // State register; reset parks in DONE so a half-seen frame is skipped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_DONE;
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      stat_q      <= '0;
      is_rd_q     <= 1'b0;
      bad_q       <= 1'b0;
      rd_wait_q   <= 1'b0;
      rd_ok_q     <= 1'b0;
      rd_data_q   <= '0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_wr_q    <= 1'b0;
      reg_rd_q    <= 1'b0;
      frame_err_q <= 1'b0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      stat_q      <= stat_d;
      is_rd_q     <= is_rd_d;
      bad_q       <= bad_d;
      rd_wait_q   <= rd_wait_d;
      rd_ok_q     <= rd_ok_d;
      rd_data_q   <= rd_data_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_wr_q    <= reg_wr_d;
      reg_rd_q    <= reg_rd_d;
      frame_err_q <= frame_err_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q;
  assign reg_addr    = reg_addr_q;
  assign reg_wdata   = reg_wdata_q;
  assign reg_wr      = reg_wr_q;
  assign reg_rd      = reg_rd_q;
  assign frame_err   = frame_err_q;

endmodule
